// File: rtl/branch_resolver.sv
// branch_resolver: turns EX-stage comparator flags plus a branch opcode into a
// taken/not-taken decision and a fetch redirect. A taken branch holds a redirect
// request until fetch accepts it, then keeps flush high for FLUSH_CYCLES more cycles.
// Optional build macro: BRANCH_RESOLVER_STATS_EN adds saturating taken/not-taken counters.
//
// Handshakes: a transfer happens on a rising Clk edge where valid and ready are both
// high; valid-side payload must stay stable while valid is high and ready is low, and
// ready carries no meaning while valid is low.
module branch_resolver #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_op,
    input  logic              beq,
    input  logic              blt,
    input  logic              bgt,
    input  logic              zero,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [ADDR_W-1:0] offset,
    output logic              resolve_valid,
    output logic              taken,
    output logic              flag_err,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_ready,
    output logic              flush,
`ifdef BRANCH_RESOLVER_STATS_EN
    output logic [15:0]       taken_cnt,
    output logic [15:0]       nt_cnt,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                resolve_valid_q, resolve_valid_d;
    logic                taken_q, taken_d;
    logic                flag_err_q, flag_err_d;
    logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;

    logic                accept;
    logic                flags_legal;
    logic                is_rel_op;
    logic                cond;
    logic                dec_taken;
    logic                dec_err;
    logic [ADDR_W-1:0]   target;

    assign br_ready = (state_q == S_IDLE) & ~Rst;
    assign accept   = br_valid & br_ready;

    // Decode the branch condition from opcode and comparator flags; compute target.
    always_comb begin
        cond        = 1'b0;
        // exactly one of beq/blt/bgt high: odd parity and not all three
        flags_legal = (beq ^ blt ^ bgt) & ~(beq & blt & bgt);
        // BEZ (6) and JMP (7) do not depend on the relation flags
        is_rel_op   = ~(br_op[2] & br_op[1]);
        case (br_op)
            3'd0:    cond = beq;
            3'd1:    cond = ~beq;
            3'd2:    cond = blt;
            3'd3:    cond = bgt;
            3'd4:    cond = blt | beq;
            3'd5:    cond = bgt | beq;
            3'd6:    cond = zero;
            3'd7:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
        dec_taken = is_rel_op ? (cond & flags_legal) : cond;
        dec_err   = is_rel_op & ~flags_legal;
        // word offset scaled to bytes; overflow wraps silently
        target    = pc_in + (offset << 2);
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        resolve_valid_d = accept;
        taken_d         = taken_q;
        flag_err_d      = accept & dec_err;
        redirect_pc_d   = redirect_pc_q;

        if (accept) begin
            taken_d = dec_taken;
            if (dec_taken) begin
                redirect_pc_d = target;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept && dec_taken) begin
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FLUSH;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending redirect or flush at once.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            resolve_valid_q <= 1'b0;
            taken_q         <= 1'b0;
            flag_err_q      <= 1'b0;
            redirect_pc_q   <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            resolve_valid_q <= resolve_valid_d;
            taken_q         <= taken_d;
            flag_err_q      <= flag_err_d;
            redirect_pc_q   <= redirect_pc_d;
        end
    end

    assign resolve_valid  = resolve_valid_q;
    assign taken          = taken_q;
    assign flag_err       = flag_err_q;
    assign redirect_pc    = redirect_pc_q;
    assign redirect_valid = (state_q == S_REDIRECT);
    assign flush          = (state_q == S_REDIRECT) | (state_q == S_FLUSH);
    assign dbg_state      = state_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [15:0] nt_cnt_q, nt_cnt_d;

    // Saturating decision counters, stepped on each resolve pulse.
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        nt_cnt_d    = nt_cnt_q;
        if (resolve_valid_q) begin
            if (taken_q) begin
                if (taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
            end else begin
                if (nt_cnt_q != 16'hFFFF) nt_cnt_d = nt_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            taken_cnt_q <= '0;
            nt_cnt_q    <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            nt_cnt_q    <= nt_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign nt_cnt    = nt_cnt_q;
`endif

endmodule
